display_resultado: RTL and testbench
====================================

DISPLAY_RESULTADO -- requirements
Module: display_resultado

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 50000, giving clk cycles per displayed digit (must be >=2).
REQ-002 SHALL provide parameter BLANK_ZEROS, default 1; when 1, leading zeros are blanked.
REQ-003 SHALL provide port clk, input, 1 bit: clock; all state changes on rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL provide port dato_in, input, 13 bits: unsigned binary value to display (0..8191).
REQ-006 SHALL provide port dato_valid, input, 1 bit: load request, sampled on each rising edge.
REQ-007 SHALL provide port busy, output, 1 bit: conversion in progress.
REQ-008 SHALL provide port bcd, output, 16 bits: four BCD digits; [15:12] thousands, [3:0] units.
REQ-009 SHALL provide port bcd_valid, output, 1 bit: one-cycle pulse when bcd updates.
REQ-010 SHALL provide port anodos, output, 4 bits: active-low digit enables; bit 0 selects units.
REQ-011 SHALL provide port segmentos, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE with dato_valid=1 at edge k, SHALL load a 29-bit register {16'b0, dato_in}, clear the iteration counter and enter SHIFT.
REQ-014 In SHIFT, each edge SHALL add 3 to every BCD nibble >=5, then shift the register left by 1 (double-dabble).
REQ-015 SHALL perform exactly 13 SHIFT iterations (edges k+1..k+13), entering DONE on edge k+13.
REQ-016 On edge k+14 (DONE), SHALL write bcd <= register[28:13], set bcd_valid=1 and return to IDLE.
REQ-017 bcd_valid SHALL be high for exactly one cycle per accepted load; latency from the dato_valid sample edge to the bcd_valid rising edge is 14 clk.
REQ-018 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-019 dato_valid while busy=1 SHALL be ignored, with no queuing.
REQ-020 dato_valid in the cycle bcd_valid is high (state IDLE) SHALL be accepted normally.
REQ-021 bcd SHALL hold its previous value during conversion; the display never shows partial results.
REQ-022 The refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-023 anodos SHALL be the active-low one-hot of the digit index (index 0 -> 4'b1110); exactly one digit is enabled at any time.
REQ-024 segmentos SHALL decode the selected bcd nibble, active-low gfedcba:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- nibbles 10..15 = 1111111
REQ-025 With BLANK_ZEROS=1, digits 3..1 SHALL show 1111111 while they and all higher digits are zero; digit 0 is always shown.
REQ-026 The anodos/segmentos path SHALL be registered, so outputs change one clk after the digit-index change, and SHALL be glitch-free.
REQ-027 Display scanning SHALL run independently of the conversion FSM.

Reset
REQ-028 rst=1 SHALL immediately force:
- state IDLE
- busy=0, bcd=16'h0000, bcd_valid=0
- refresh counter 0, digit index 0
- anodos=4'b1110, segmentos=7'b1000000
REQ-029 rst asserted mid-conversion SHALL abort it: no bcd_valid pulse and bcd=0.
REQ-030 After rst deasserts, the first dato_valid at a rising edge SHALL be accepted.

Verification
REQ-031 dato_in=0, dato_valid 1 cycle -> bcd_valid exactly 14 clk later, bcd=16'h0000, busy high for 14 cycles.
REQ-032 dato_in=8190 (4095+4095) -> bcd=16'h8190; dato_in=8191 -> bcd=16'h8191.
REQ-033 dato_in=1234 loaded, then dato_valid with 999 at cycle 5 of busy -> single bcd_valid, bcd=16'h1234.
REQ-034 REFRESH_DIV=4, BLANK_ZEROS=1, bcd=16'h0042 -> anodos cycles 1110,1101,1011,0111 (4 clk each); segmentos 0100100, 0011001, 1111111, 1111111.
REQ-035 rst pulsed 5 clk after load of 4000 -> busy=0, bcd=0, no bcd_valid pulse; next load of 4000 -> bcd=16'h4000.
REQ-036 Exhaustive sweep 0..8191 back-to-back loads -> every bcd matches decimal of dato_in; one bcd_valid per load.

Source files
------------

// File: rtl/display_resultado.sv
// display_resultado: converts a 13-bit binary value to four BCD digits with a
// sequential double-dabble engine, and scans the held result onto a
// multiplexed 4-digit common-anode 7-segment display.
module display_resultado #(
    parameter int REFRESH_DIV = 50000,   // clk cycles each digit stays lit (>= 2)
    parameter int BLANK_ZEROS = 1        // 1: suppress leading zeros on digits 3..1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] dato_in,
    input  logic        dato_valid,
    output logic        busy,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic [3:0]  anodos,
    output logic [6:0]  segmentos
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t      state, state_nxt;
    logic [28:0] sr;        // {thousands, hundreds, tens, units, binary}
    logic [28:0] sr_adj;    // sr with every BCD nibble >= 5 corrected by +3
    logic [3:0]  iter;
    logic [RW-1:0] ref_cnt;
    logic [1:0]  dig;
    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  seg_nxt;
    logic [3:0]  an_nxt;

    assign busy = (state != IDLE);

    // Conversion FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: load in IDLE, 13 shift steps (iter 0..12), one publish cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dato_valid) state_nxt = SHIFT;
            SHIFT:   if (iter == 4'd12) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction on the four BCD nibbles ahead of the shift.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++) begin
            if (sr[13 + 4*i +: 4] >= 4'd5)
                sr_adj[13 + 4*i +: 4] = sr[13 + 4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath; bcd only changes when a full conversion finishes,
    // so the display never sees intermediate digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            iter      <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (dato_valid) begin
                        sr   <= {16'b0, dato_in};
                        iter <= '0;
                    end
                end
                SHIFT: begin
                    sr   <= sr_adj << 1;
                    iter <= iter + 4'd1;
                end
                DONE: begin
                    bcd       <= sr[28:13];
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Scan timebase: digit index advances each time the refresh counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            dig     <= '0;
        end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            dig     <= dig + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Select the nibble for the current digit, apply blanking, decode.
    always_comb begin
        nib = bcd[{dig, 2'b00} +: 4];
        case (dig)
            2'd1:    blank = (bcd[15:4]  == 12'd0);
            2'd2:    blank = (bcd[15:8]  == 8'd0);
            2'd3:    blank = (bcd[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        if (BLANK_ZEROS == 0) blank = 1'b0;
        case (nib)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = 7'b1111111;
        endcase
        if (blank) seg_nxt = 7'b1111111;
        an_nxt = ~(4'b0001 << dig);
    end

    // Registered display drive so anodes and segments switch together, glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodos    <= 4'b1110;
            segmentos <= 7'b1000000;
        end else begin
            anodos    <= an_nxt;
            segmentos <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_display_resultado.sv
// Bench for display_resultado: a decimal-arithmetic model is checked against the
// DUT every cycle, plus directed literal expectations for key scenarios.
module tb_display_resultado;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] dato_in;
    logic        dato_valid;
    logic        busy;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic [3:0]  anodos;
    logic [6:0]  segmentos;

    always #5 clk = ~clk;

    display_resultado #(.REFRESH_DIV(4), .BLANK_ZEROS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .dato_in    (dato_in),
        .dato_valid (dato_valid),
        .busy       (busy),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .anodos     (anodos),
        .segmentos  (segmentos)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // literal expectations handed from the stimulus to the compare process
    int          lit_seq  = 0;
    int          lit_done = 0;
    string       lit_name;
    logic [31:0] lit_act, lit_exp;

    // behavioural model state
    int         m_rem, m_pend, m_val, m_ref, m_idx;
    logic       m_valid;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Model: result appears 14 edges after acceptance; display shows the held
    // decimal value, one digit per 4 clocks, leading zeros blanked.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem = 0; m_pend = 0; m_val = 0; m_valid = 1'b0;
            m_ref = 0; m_idx = 0; m_an = 4'b1110; m_seg = 7'b1000000;
        end else begin
            m_an = ~(4'b0001 << m_idx);
            if (m_idx > 0 && m_val < 10**m_idx) m_seg = 7'b1111111;
            else m_seg = seg_of((m_val / 10**m_idx) % 10);
            if (m_ref == 3) begin m_ref = 0; m_idx = (m_idx + 1) % 4; end
            else m_ref++;
            m_valid = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin m_val = m_pend; m_valid = 1'b1; end
            end else if (dato_valid) begin
                m_pend = int'(dato_in);
                m_rem  = 14;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process: model vs DUT every cycle, plus posted literals.
    always @(negedge clk) begin
        chk("busy",      {31'd0, busy},       {31'd0, (m_rem > 0)});
        chk("bcd_valid", {31'd0, bcd_valid},  {31'd0, m_valid});
        chk("bcd",       {16'd0, bcd},        {16'd0, to_bcd(m_val)});
        chk("anodos",    {28'd0, anodos},     {28'd0, m_an});
        chk("segmentos", {25'd0, segmentos},  {25'd0, m_seg});
        if (lit_seq != lit_done) begin
            chk(lit_name, lit_act, lit_exp);
            lit_done = lit_seq;
        end
    end

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_name = nm; lit_act = act; lit_exp = exp;
        lit_seq++;
        @(negedge clk); #1;
    endtask

    // Load a value and wait (bounded) for the result; returns latency and busy cycles.
    task automatic do_load(input logic [12:0] v, output int lat, output int bc);
        dato_in = v; dato_valid = 1'b1;
        @(posedge clk); #1;
        dato_valid = 1'b0;
        lat = 0;
        bc  = busy ? 1 : 0;
        while (!bcd_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bc++;
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bcd_valid) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] sg_exp [4] = '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111};

    initial begin
        int lat, bc, np, bad, w;
        logic [3:0] an_cap [4];
        logic [6:0] sg_cap [4];

        rst = 1'b1; dato_valid = 1'b0; dato_in = '0;
        repeat (2) @(posedge clk);
        #1;
        post("rst_busy",  {31'd0, busy},      32'd0);
        post("rst_bcd",   {16'd0, bcd},       32'h0000);
        post("rst_valid", {31'd0, bcd_valid}, 32'd0);
        post("rst_an",    {28'd0, anodos},    32'b1110);
        post("rst_seg",   {25'd0, segmentos}, 32'b1000000);
        @(posedge clk); #1;
        rst = 1'b0;

        // zero: latency and busy width
        do_load(13'd0, lat, bc);
        post("zero_latency", lat, 14);
        post("zero_busy_cycles", bc, 14);
        post("zero_bcd", {16'd0, bcd}, 32'h0000);

        // upper boundary values
        do_load(13'd8190, lat, bc);
        post("bcd_8190", {16'd0, bcd}, 32'h8190);
        do_load(13'd8191, lat, bc);
        post("bcd_8191", {16'd0, bcd}, 32'h8191);

        // load while busy is ignored
        dato_in = 13'd1234; dato_valid = 1'b1;
        @(posedge clk); #1;
        dato_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        dato_in = 13'd999; dato_valid = 1'b1;
        @(posedge clk); #1;
        dato_valid = 1'b0;
        w = 0;
        while (!bcd_valid && w < 40) begin @(posedge clk); #1; w++; end
        post("busy_ignore_seen", {31'd0, bcd_valid}, 32'd1);
        post("busy_ignore_bcd", {16'd0, bcd}, 32'h1234);
        count_pulses(30, np);
        post("busy_ignore_extra_pulses", np, 0);

        // display scan of 42
        do_load(13'd42, lat, bc);
        post("bcd_42", {16'd0, bcd}, 32'h0042);
        repeat (2) @(posedge clk);
        #1;
        w = 0;
        while (anodos != 4'b1110 && w < 20) begin @(posedge clk); #1; w++; end
        for (int d = 0; d < 4; d++) begin
            an_cap[d] = anodos; sg_cap[d] = segmentos;
            repeat (4) @(posedge clk);
            #1;
        end
        for (int d = 0; d < 4; d++) begin
            post("scan_anodos",    {28'd0, an_cap[d]}, {28'd0, an_exp[d]});
            post("scan_segmentos", {25'd0, sg_cap[d]}, {25'd0, sg_exp[d]});
        end

        // reset mid-conversion aborts
        @(posedge clk); #1;
        dato_in = 13'd4000; dato_valid = 1'b1;
        @(posedge clk); #1;
        dato_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        post("abort_busy", {31'd0, busy}, 32'd0);
        post("abort_bcd",  {16'd0, bcd},  32'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        count_pulses(20, np);
        post("abort_no_pulse", np, 0);
        do_load(13'd4000, lat, bc);
        post("after_abort_bcd", {16'd0, bcd}, 32'h4000);

        // back-to-back sweep: next load issued in the bcd_valid cycle
        bad = 0;
        for (int v = 1; v < 8192; v += 61) begin
            do_load(13'(v), lat, bc);
            if (lat != 14 || bcd !== to_bcd(v)) bad++;
        end
        do_load(13'd8191, lat, bc);
        if (lat != 14 || bcd !== 16'h8191) bad++;
        post("sweep_bad_loads", bad, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
